// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO.
// Framing and overrun conditions are held in sticky flags until cleared.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_in,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
   localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
   localparam logic [AddrW:0]  FullCnt = (AddrW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   state_e           state_q, state_d;
   logic [CntW-1:0]  clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   logic push, frame_set, pop_ok, push_ok, full, ovr_set;

   assign rx_meta_d = rx_in;
   assign rx_s_d    = rx_meta_q;

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d   = StStart;
               clk_cnt_d = '0;
            end
         end
         StStart: begin
            if (clk_cnt_q == HalfCnt) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? StIdle : StData;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (clk_cnt_q == LastCnt) begin
               shift_d[bit_idx_q] = rx_s_q;
               clk_cnt_d          = '0;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (clk_cnt_q == LastCnt) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  push    = 1'b1;
                  state_d = StIdle;
               end else begin
                  frame_set = 1'b1;
                  state_d   = StBreak;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         // Hold here until the line returns high so a stuck-low line cannot retrigger.
         StBreak: begin
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      full     = (count_q == FullCnt);
      pop_ok   = rd_en && (count_q != '0);
      push_ok  = push && (!full || pop_ok);
      ovr_set  = push && full && !pop_ok;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AddrW + 1)'(1);
         2'b01:   count_d = count_q - (AddrW + 1)'(1);
         default: count_d = count_q;
      endcase
      // A set event in the same cycle as a clear takes precedence.
      frame_err_d = (frame_err_q & ~clr_err) | frame_set;
      overrun_d   = (overrun_q & ~clr_err) | ovr_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= StIdle;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_valid   = (count_q != '0);
   assign rd_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign fifo_count = count_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames in, scoreboard of expected bytes out.
module tb_uart_rx_fifo;

   localparam int unsigned Cpb   = 16;
   localparam int unsigned Depth = 8;

   logic       clk = 1'b0;
   logic       reset, rx_in, rd_en, clr_err;
   logic [7:0] rd_data;
   logic       rx_valid, frame_err, overrun;
   logic [3:0] fifo_count;

   uart_rx_fifo #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .rd_en      (rd_en),
      .clr_err    (clr_err),
      .rd_data    (rd_data),
      .rx_valid   (rx_valid),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb_q [$];
   logic       exp_ferr, exp_ovr;
   logic [3:0] cnt_pre, cnt_post;
   logic [7:0] partial_byte;

   typedef struct {
      logic [7:0] data;
      logic [3:0] exp_count;
      logic       exp_ovr;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Stop-bit sample lands on the posedge between the 154th and 155th negedge after the start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_sample);
      rx_in = 1'b1;
      cycles(4);
      rx_in = 1'b0;
      cycles(Cpb);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         cycles(Cpb);
      end
      rx_in = stop;
      cycles(10);
      cnt_pre = fifo_count;
      if (pop_at_sample) begin
         chk("collide_head", {24'h0, rd_data}, {24'h0, sb_q[0]});
         rd_en = 1'b1;
         void'(sb_q.pop_front());
      end
      cycles(1);
      rd_en    = 1'b0;
      cnt_post = fifo_count;
      if (stop) begin
         if (sb_q.size() < Depth) sb_q.push_back(b);
         else exp_ovr = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
      cycles(5);
   endtask

   task automatic pop_check(input string name);
      chk({name, "_valid"}, {31'h0, rx_valid}, 32'd1);
      chk({name, "_data"}, {24'h0, rd_data}, {24'h0, sb_q[0]});
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
      void'(sb_q.pop_front());
      chk({name, "_count"}, {28'h0, fifo_count}, sb_q.size());
   endtask

   task automatic check_reset_state(input string name);
      chk({name, "_rd_data"}, {24'h0, rd_data}, 32'h0);
      chk({name, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
      chk({name, "_count"}, {28'h0, fifo_count}, 32'h0);
      chk({name, "_frame_err"}, {31'h0, frame_err}, 32'h0);
      chk({name, "_overrun"}, {31'h0, overrun}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{data: 8'h00, exp_count: 4'd1, exp_ovr: 1'b0};
      vecs[1] = '{data: 8'h01, exp_count: 4'd2, exp_ovr: 1'b0};
      vecs[2] = '{data: 8'h02, exp_count: 4'd3, exp_ovr: 1'b0};
      vecs[3] = '{data: 8'h03, exp_count: 4'd4, exp_ovr: 1'b0};
      vecs[4] = '{data: 8'h04, exp_count: 4'd5, exp_ovr: 1'b0};
      vecs[5] = '{data: 8'h05, exp_count: 4'd6, exp_ovr: 1'b0};
      vecs[6] = '{data: 8'h06, exp_count: 4'd7, exp_ovr: 1'b0};
      vecs[7] = '{data: 8'h07, exp_count: 4'd8, exp_ovr: 1'b0};
      vecs[8] = '{data: 8'h08, exp_count: 4'd8, exp_ovr: 1'b1};

      reset    = 1'b1;
      rx_in    = 1'b1;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      cycles(3);
      reset = 1'b0;
      check_reset_state("reset");

      // Single byte with push timing
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("single_cnt_pre", {28'h0, cnt_pre}, 32'd0);
      chk("single_cnt_post", {28'h0, cnt_post}, 32'd1);
      pop_check("single");
      chk("single_empty_valid", {31'h0, rx_valid}, 32'd0);
      chk("single_empty_data", {24'h0, rd_data}, 32'h0);

      // Glitch rejection
      rx_in = 1'b0;
      cycles(4);
      rx_in = 1'b1;
      cycles(30);
      chk("glitch_count", {28'h0, fifo_count}, 32'd0);
      chk("glitch_ferr", {31'h0, frame_err}, {31'h0, exp_ferr});
      send_frame(8'h3C, 1'b1, 1'b0);
      pop_check("glitch_next");

      // Framing error and break hold
      send_frame(8'h3C, 1'b0, 1'b0);
      cycles(40);
      chk("frame_err_set", {31'h0, frame_err}, {31'h0, exp_ferr});
      chk("frame_count", {28'h0, fifo_count}, 32'd0);
      send_frame(8'h55, 1'b1, 1'b0);
      chk("frame_sticky", {31'h0, frame_err}, 32'd1);
      pop_check("frame_next");
      clr_err = 1'b1;
      cycles(1);
      clr_err  = 1'b0;
      exp_ferr = 1'b0;
      chk("frame_clr", {31'h0, frame_err}, {31'h0, exp_ferr});

      // Overrun from the vector table
      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].data, 1'b1, 1'b0);
         chk($sformatf("ovr_count_%0d", i), {28'h0, fifo_count}, {28'h0, vecs[i].exp_count});
         chk($sformatf("ovr_flag_%0d", i), {31'h0, overrun}, {31'h0, vecs[i].exp_ovr});
      end
      for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_drain_%0d", i));
      chk("ovr_empty", {31'h0, rx_valid}, 32'd0);
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
      chk("underflow_count", {28'h0, fifo_count}, 32'd0);
      chk("underflow_data", {24'h0, rd_data}, 32'h0);
      clr_err = 1'b1;
      cycles(1);
      clr_err = 1'b0;
      exp_ovr = 1'b0;
      chk("ovr_clr", {31'h0, overrun}, {31'h0, exp_ovr});

      // Full FIFO with pop on the exact stop-sample cycle
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      chk("collide_full", {28'h0, fifo_count}, 32'd8);
      send_frame(8'h99, 1'b1, 1'b1);
      chk("collide_cnt_post", {28'h0, cnt_post}, 32'd8);
      chk("collide_overrun", {31'h0, overrun}, {31'h0, exp_ovr});
      for (int i = 0; i < 7; i++) pop_check($sformatf("collide_drain_%0d", i));
      chk("collide_last", {24'h0, rd_data}, 32'h99);
      pop_check("collide_final");
      chk("collide_empty", {31'h0, rx_valid}, 32'd0);

      // Reset during data bit 3 with bytes queued and a flag set
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h02, 1'b0, 1'b0);
      send_frame(8'h03, 1'b1, 1'b0);
      chk("prereset_count", {28'h0, fifo_count}, 32'd2);
      chk("prereset_ferr", {31'h0, frame_err}, {31'h0, exp_ferr});
      partial_byte = 8'hF0;
      rx_in = 1'b1;
      cycles(4);
      rx_in = 1'b0;
      cycles(Cpb);
      for (int i = 0; i < 3; i++) begin
         rx_in = partial_byte[i];
         cycles(Cpb);
      end
      rx_in = partial_byte[3];
      cycles(6);
      reset = 1'b1;
      rx_in = 1'b1;
      cycles(1);
      reset = 1'b0;
      sb_q.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      check_reset_state("midreset");
      send_frame(8'h81, 1'b1, 1'b0);
      chk("after_reset_data", {24'h0, rd_data}, 32'h81);
      chk("after_reset_count", {28'h0, fifo_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Memory-mapped UART receive front end that feeds the GPIO/MMIO block's byte and byte-ready read ports. It synchronises the serial RX pin, deframes 8N1 characters with mid-bit sampling, and buffers received bytes in a small FIFO. The CPU pops bytes through the GPIO load path, so no character is lost between polls. Framing and overrun errors are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rx_in  input  1  asynchronous serial line; idle high.
rd_en  input  1  pop request from the GPIO load path (one-cycle pulse).
clr_err  input  1  clears frame_err and overrun.
rd_data  output  8  FIFO head byte (first-word fall-through).
rx_valid  output  1  FIFO not empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
frame_err  output  1  sticky; a stop bit was sampled low.
overrun  output  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - FSM = IDLE; bit counter and clock counter = 0.
  - FIFO empty, pointers = 0.
  - rd_data = 8'h00, rx_valid = 0, fifo_count = 0, frame_err = 0, overrun = 0.
- Reset mid-frame discards the partial byte and all FIFO contents. Reception restarts at the next falling edge after reset deasserts.
- rx_in passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s.
- FSM states and transitions:
  - IDLE: when rx_s == 0 → START, clock counter = 0.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division).
    - If rx_s == 0 at that point → DATA, clock counter = 0, bit index = 0.
    - Otherwise glitch → IDLE, nothing recorded.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit index], LSB first.
    - After bit index 7 → STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: push the byte → IDLE.
    - If 0: set frame_err, discard the byte → BREAK.
  - BREAK: wait until rx_s == 1 → IDLE. This prevents a held-low line from retriggering.
- Push timing: on the stop-sample cycle. rx_valid and fifo_count reflect the push on the following cycle.
- Push when full: the byte is dropped and overrun is set, unless a pop occurs in the same cycle (see below).
- Pop: rd_en with rx_valid == 1 advances the read pointer on that edge. rd_en with rx_valid == 0 is ignored, with no underflow.
- Simultaneous push and pop:
  - Both are performed; fifo_count is unchanged.
  - This applies when full: the pop frees the slot, the push is accepted, and overrun is not set.
  - When empty, the push happens and the pop is ignored.
- rd_data = mem[rd_ptr] whenever rx_valid; 8'h00 when empty. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_err clears both. A set event in the same cycle as clr_err wins, and the flag reads 1.
- The FIFO keeps accepting bytes while the error flags are set.

Test Plan:
All tests use CLKS_PER_BIT=16, FIFO_DEPTH=8.
- Single byte: send 0xA5 (8N1) → rx_valid=1 and fifo_count=1 one cycle after the stop-bit sample; rd_data=0xA5. Pulse rd_en → rx_valid=0, fifo_count=0, rd_data=0x00.
- Glitch reject: 4-cycle low pulse on idle rx_in → FSM returns to IDLE, fifo_count stays 0. A following 0x3C is received correctly.
- Framing error: send 0x3C with the stop bit low, then hold low 40 cycles and release → frame_err=1, fifo_count=0. Next frame 0x55 → rd_data=0x55, frame_err still 1. Pulse clr_err → 0.
- Overrun: send 0x00..0x08 with no pops → fifo_count=8, overrun=1. Eight pops return 0x00..0x07 in order, then rx_valid=0.
- Full push+pop collision: FIFO holds 8 bytes; rd_en on the exact stop-sample cycle of 0x99 → fifo_count stays 8, overrun=0. 0x99 is popped last.
- Reset mid-frame: assert reset for 1 cycle during data bit 3 of 0xF0, with 2 bytes already queued → all outputs at reset values. A next frame of 0x81 gives rd_data=0x81, fifo_count=1.
